// File: rtl/act_pkg.sv
// Shared constants and FSM state type for the activation sequencer.
// Geometry defaults describe a 2 x 28 x 28 feature map.
package act_pkg;
   localparam int BITWIDTH_D = 32;
   localparam int CHANNELS_D = 2;
   localparam int DIM_D      = 28;
   localparam int N_ELEM     = 1568;
   localparam int ADDR_W     = 11;
   localparam int FIFO_DEPTH = 3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;
endpackage

// File: rtl/act_if.sv
// Control, source-read and destination-write bundle of the sequencer.
// master = environment side, slave = sequencer side.
interface act_if
   import act_pkg::*;
#(
   parameter int BITWIDTH = BITWIDTH_D
);
   logic                start;
   logic                busy;
   logic                done;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic [BITWIDTH-1:0] rd_data;
   logic                wr_valid;
   logic                wr_ready;
   logic [ADDR_W-1:0]   wr_addr;
   logic [BITWIDTH-1:0] wr_data;
   logic [ADDR_W-1:0]   clip_count;

   modport master (
      output start, rd_data, wr_ready,
      input  busy, done, rd_en, rd_addr,
      input  wr_valid, wr_addr, wr_data, clip_count
   );

   modport slave (
      input  start, rd_data, wr_ready,
      output busy, done, rd_en, rd_addr,
      output wr_valid, wr_addr, wr_data, clip_count
   );
endinterface

// File: rtl/act_skid_fifo.sv
// Three-entry circular FIFO absorbing reads still in flight when the
// destination stalls; push and pop may coincide.
module act_skid_fifo
   import act_pkg::*;
#(
   parameter int W = BITWIDTH_D
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic [1:0]   count_o
);
   logic [W-1:0] mem_q [FIFO_DEPTH];
   logic [1:0]   wp_q;
   logic [1:0]   rp_q;
   logic [1:0]   cnt_q;

   function automatic logic [1:0] nxt(input logic [1:0] p);
      return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= 2'd0;
         rp_q  <= 2'd0;
         cnt_q <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wp_q] <= din_i;
            wp_q        <= nxt(wp_q);
         end
         if (pop_i) rp_q <= nxt(rp_q);
         cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign head_o  = mem_q[rp_q];
   assign count_o = cnt_q;
endmodule

// File: rtl/activation_sequencer_1.sv
// Streams a feature map from a source buffer through ReLU into a
// destination, with credit-limited reads and a 3-deep skid FIFO.
module activation_sequencer_1
   import act_pkg::*;
#(
   parameter int BITWIDTH = BITWIDTH_D,
   parameter int CHANNELS = CHANNELS_D,
   parameter int DIM      = DIM_D
) (
   input logic clk,
   input logic rst,
   act_if.slave bus
);
   localparam int N = CHANNELS * DIM * DIM;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

   state_e              state_q;
   logic                busy_q;
   logic                done_q;
   logic                rd_en_q;
   logic                rd_v_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [ADDR_W-1:0]   clip_q;
   logic [BITWIDTH-1:0] head;
   logic [1:0]          cnt;
   logic                wr_valid;
   logic                push;
   logic                pop;
   logic [2:0]          occ_nxt;
   logic                credit_ok;

   act_skid_fifo #(.W(BITWIDTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (bus.rd_data),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (cnt)
   );

   assign wr_valid = (cnt != 2'd0);
   assign push     = rd_v_q;
   assign pop      = wr_valid && bus.wr_ready;

   // Next-cycle occupancy plus the read now on the bus bounds the next issue.
   assign occ_nxt   = {1'b0, cnt} + {2'b0, push} - {2'b0, pop}
                    + {2'b0, rd_en_q};
   assign credit_ok = (occ_nxt < 3'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_v_q    <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         clip_q    <= '0;
      end else begin
         done_q <= 1'b0;
         rd_v_q <= rd_en_q;
         if (pop) begin
            if (head[BITWIDTH-1]) clip_q <= clip_q + ADDR_W'(1);
            if (wr_addr_q != LAST) wr_addr_q <= wr_addr_q + ADDR_W'(1);
         end
         if (rd_en_q && rd_addr_q != LAST) rd_addr_q <= rd_addr_q + ADDR_W'(1);
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q   <= RUN;
                  busy_q    <= 1'b1;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= '0;
                  wr_addr_q <= '0;
                  clip_q    <= '0;
               end
            end
            RUN: begin
               if (rd_en_q && rd_addr_q == LAST) begin
                  state_q <= DRAIN;
                  rd_en_q <= 1'b0;
               end else begin
                  rd_en_q <= credit_ok;
               end
            end
            DRAIN: begin
               if (pop && wr_addr_q == LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.rd_en      = rd_en_q;
   assign bus.rd_addr    = rd_addr_q;
   assign bus.wr_valid   = wr_valid;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = head[BITWIDTH-1] ? '0 : head;
   assign bus.clip_count = clip_q;
endmodule

// File: tb/tb_activation_sequencer_1.sv
// Directed bench: full passes under several ready patterns, restart,
// mid-pass reset and saturating data, checked against a local model.
module tb_activation_sequencer_1;
   import act_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks;
   int   errors;
   int   mode;
   logic        pend;
   logic [10:0] maddr;

   act_if #(.BITWIDTH(32)) bus ();

   activation_sequencer_1 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] src(input int md, input int a);
      if (md == 1) return a[0] ? 32'h7FFF_FFFF : 32'h8000_0000;
      return 32'(a - 392);
   endfunction

   function automatic logic [31:0] relu(input logic [31:0] x);
      return ($signed(x) < 0) ? 32'h0 : x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_vals(input string t);
      chk({t, "_busy"}, {31'b0, bus.busy}, 0);
      chk({t, "_done"}, {31'b0, bus.done}, 0);
      chk({t, "_rd_en"}, {31'b0, bus.rd_en}, 0);
      chk({t, "_wr_valid"}, {31'b0, bus.wr_valid}, 0);
      chk({t, "_rd_addr"}, {21'b0, bus.rd_addr}, 0);
      chk({t, "_wr_addr"}, {21'b0, bus.wr_addr}, 0);
      chk({t, "_clip"}, {21'b0, bus.clip_count}, 0);
   endtask

   // Source buffer: word for a read strobed in cycle c appears in c+1.
   always begin
      @(negedge clk);
      pend  = bus.rd_en;
      maddr = bus.rd_addr;
      @(posedge clk);
      #1;
      bus.rd_data = pend ? src(mode, int'(maddr)) : 32'hDEAD_BEEF;
   end

   task automatic run_pass(input int md, input int rm, input int st2,
                           input int rs, input int exp_clip);
      int c, issued, acc, last_hs, last_rd, stall_wr;
      bit stalled, fin, rdy;
      logic [31:0] pdata;
      logic [10:0] paddr;
      mode = md;
      issued = 0; acc = 0; last_hs = 0; last_rd = 0; stall_wr = 0;
      stalled = 0; fin = 0; pdata = '0; paddr = '0;
      bus.wr_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      c = 1;
      chk("first_rd", {31'b0, bus.rd_en}, 1);
      chk("first_addr", {21'b0, bus.rd_addr}, 0);
      chk("busy", {31'b0, bus.busy}, 1);
      while (!fin && c < 8000) begin
         case (rm)
            1: rdy = c[0];
            2: rdy = !(c >= 200 && c < 220);
            default: rdy = 1'b1;
         endcase
         bus.wr_ready = rdy;
         bus.start = (c == st2);
         if (c == rs) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            rst_vals("midrst");
            repeat (10) begin
               tick();
               chk("midrst_done", {31'b0, bus.done}, 0);
               chk("midrst_rd_en", {31'b0, bus.rd_en}, 0);
               chk("midrst_wv", {31'b0, bus.wr_valid}, 0);
            end
            return;
         end
         if (bus.rd_en) begin
            chk("credit", {31'b0, (issued - acc) < 3}, 1);
            chk("rd_addr", {21'b0, bus.rd_addr}, issued);
            last_rd = int'(bus.rd_addr);
            issued++;
         end
         if (stalled) begin
            chk("hold_data", bus.wr_data, pdata);
            chk("hold_addr", {21'b0, bus.wr_addr}, {21'b0, paddr});
         end
         if (rm == 2 && c == 200) stall_wr = int'(bus.wr_addr);
         if (rm == 2 && c >= 201 && c < 220)
            chk("stall_rd_en", {31'b0, bus.rd_en}, 0);
         if (rm == 2 && c == 219) chk("stall_reads", last_rd, stall_wr + 2);
         if (bus.wr_valid && rdy) begin
            chk("wr_addr", {21'b0, bus.wr_addr}, acc);
            chk("wr_data", bus.wr_data, relu(src(md, acc)));
            acc++;
            last_hs = c;
         end
         if (bus.done) begin
            chk("done_lat", c, last_hs + 1);
            chk("done_cnt", acc, N_ELEM);
            chk("busy_at_done", {31'b0, bus.busy}, 0);
            chk("clip", {21'b0, bus.clip_count}, exp_clip);
            if (rm == 0) chk("done_cyc", c, N_ELEM + 3);
            fin = 1'b1;
         end
         stalled = bus.wr_valid && !rdy;
         pdata = bus.wr_data;
         paddr = bus.wr_addr;
         tick();
         c++;
      end
      if (!fin) chk("timeout", 0, 1);
      bus.start = 1'b0;
      bus.wr_ready = 1'b1;
      repeat (5) begin
         tick();
         chk("no_2nd_done", {31'b0, bus.done}, 0);
         chk("clip_hold", {21'b0, bus.clip_count}, exp_clip);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mode = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.wr_ready = 1'b0;
      repeat (3) tick();
      rst_vals("reset");
      rst = 1'b0;
      tick();
      run_pass(0, 0, 0, 0, 392);
      run_pass(0, 1, 0, 0, 392);
      run_pass(0, 2, 0, 0, 392);
      run_pass(0, 0, 100, 0, 392);
      run_pass(0, 0, 0, 500, 0);
      run_pass(0, 0, 0, 0, 392);
      run_pass(1, 0, 0, 0, 784);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/activation_sequencer_1.md
ACTIVATION_SEQUENCER_1 -- requirements
Module: activation_sequencer_1

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, element width (two's-complement fixed-point).
REQ-002 SHALL have parameter CHANNELS, default 2, feature-map channel count.
REQ-003 SHALL have parameter DIM, default 28, feature-map row/column size.
REQ-004 SHALL have: clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have: start  in  1  one-cycle pulse starting a full-map pass.
REQ-007 SHALL have: busy  out  1  high from accepted start until done.
REQ-008 SHALL have: done  out  1  one-cycle pulse after the final write.
REQ-009 SHALL have: rd_en  out  1  source-buffer read strobe.
REQ-010 SHALL have: rd_addr  out  11  source address = ch*DIM*DIM + row*DIM + col.
REQ-011 SHALL have: rd_data  in  BITWIDTH  source word, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have: wr_valid  out  1  output word valid.
REQ-013 SHALL have: wr_ready  in  1  destination accepts word when high with wr_valid.
REQ-014 SHALL have: wr_addr  out  11  destination address, same mapping as rd_addr.
REQ-015 SHALL have: wr_data  out  BITWIDTH  ReLU'd word.
REQ-016 SHALL have: clip_count  out  11  number of elements whose MSB was 1 in the last/current pass.

Function
REQ-017 SHALL use FSM states IDLE, RUN, DRAIN; IDLE->RUN on start, RUN->DRAIN after last read issued, DRAIN->IDLE on final write handshake.
REQ-018 SHALL ignore start when not in IDLE.
REQ-019 SHALL traverse N = CHANNELS*DIM*DIM (1568) elements in order col fastest, then row, then channel; rd_addr increments by 1 from 0 to N-1.
REQ-020 SHALL issue first rd_en in the cycle after start is sampled.
REQ-021 SHALL issue rd_en only when FIFO occupancy + reads in flight < 3 (credit limit), guaranteeing no overflow.
REQ-022 SHALL push rd_data into a 3-entry FIFO the cycle it is valid; wr_valid = FIFO non-empty, wr_data = ReLU(FIFO head).
REQ-023 SHALL compute ReLU as: MSB of word = 1 -> all-zero; else word unchanged; no other arithmetic.
REQ-024 SHALL pop FIFO and increment wr_addr only on wr_valid && wr_ready; wr_data/wr_addr SHALL hold stable while wr_valid && !wr_ready.
REQ-025 SHALL sustain 1 element/cycle with wr_ready held high; total latency start->done = N+3 cycles.
REQ-026 SHALL increment clip_count per write handshake whose head MSB = 1; clear on accepted start; hold after done until next start.
REQ-027 SHALL pulse done one cycle after the handshake of element N-1, dropping busy in the same cycle as done.
REQ-028 SHALL allow simultaneous push and pop in one cycle with occupancy unchanged.

Reset
REQ-029 SHALL on rst: state IDLE, busy=0, done=0, rd_en=0, wr_valid=0, rd_addr=0, wr_addr=0, clip_count=0, FIFO empty, in-flight flag cleared.
REQ-030 SHALL, on rst mid-pass, abandon the pass without done and discard any rd_data returning the following cycle.

Structure
REQ-031 SHALL place BITWIDTH/CHANNELS/DIM defaults, N_ELEM=1568, ADDR_W=11 and the FSM state enum in shared package act_pkg.
REQ-032 SHALL instantiate one sub-module act_skid_fifo (3-entry, BITWIDTH wide, push/pop/count, synchronous reset).

Verification
REQ-033 SHALL test: rst, start, wr_ready=1, rd_data = addr-392 -> 1568 writes, addresses 0..1567, first 392 words zero, clip_count=392, done at cycle start+1571.
REQ-034 SHALL test: wr_ready toggling 1,0 each cycle -> no word lost/duplicated, wr_data stable while stalled, rd_en never exceeds credit of 3.
REQ-035 SHALL test: wr_ready=0 for 20 cycles mid-pass -> exactly 2 extra reads after stall begins then rd_en held low, resume without loss.
REQ-036 SHALL test: start pulsed again at cycle 100 of a pass -> ignored, single done, clip_count unchanged by it.
REQ-037 SHALL test: rst at cycle 500 of a pass -> all outputs at reset values next cycle, no done; fresh start then completes normally.
REQ-038 SHALL test: rd_data = 32'h8000_0000 and 32'h7FFF_FFFF alternating -> outputs 0 and 32'h7FFF_FFFF alternating, clip_count=784.
